// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing a 16-bit asynchronous SRAM as 32-bit words (two half-accesses each).
// Define SRAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (port 0).
module sram_arbiter #(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [16:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [16:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        SRAMWEn,
  output logic [17:0] SRAMaddress,
  inout  wire  [15:0] SRAMdata
);

  localparam int unsigned CntW = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SRAM_WAIT);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [16:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            port_q;
  logic [15:0]     rlow_q;
  logic [15:0]     dout_q;
  logic            drive_q;

  logic            grant;
  logic            sel_we;
  logic [16:0]     sel_addr;
  logic [31:0]     sel_wdata;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  // Port preferred on the next tie: the one not granted most recently.
  logic rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else if (state_q == StIdle && (p0_req || p1_req)) begin
      rr_q <= ~grant;
    end
  end

  assign grant = (p0_req && p1_req) ? rr_q : p1_req;
`else
  assign grant = ~p0_req;
`endif

  always_comb begin
    sel_we    = grant ? p1_we    : p0_we;
    sel_addr  = grant ? p1_addr  : p0_addr;
    sel_wdata = grant ? p1_wdata : p0_wdata;
  end

  assign SRAMdata = drive_q ? dout_q : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      port_q      <= 1'b0;
      rlow_q      <= '0;
      dout_q      <= '0;
      drive_q     <= 1'b0;
      SRAMWEn     <= 1'b1;
      SRAMaddress <= '0;
      p0_ready    <= 1'b0;
      p1_ready    <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state_q)
        StIdle: begin
          if (p0_req || p1_req) begin
            port_q      <= grant;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            cnt_q       <= '0;
            SRAMaddress <= {sel_addr, 1'b0};
            SRAMWEn     <= ~sel_we;
            drive_q     <= sel_we;
            dout_q      <= sel_wdata[15:0];
            state_q     <= StLow;
          end
        end
        StLow: begin
          if (cnt_q == CntMax) begin
            rlow_q      <= SRAMdata;
            cnt_q       <= '0;
            SRAMaddress <= {addr_q, 1'b1};
            dout_q      <= wdata_q[31:16];
            state_q     <= StHigh;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHigh: begin
          if (cnt_q == CntMax) begin
            SRAMWEn <= 1'b1;
            drive_q <= 1'b0;
            if (!we_q) begin
              if (port_q) p1_rdata <= {SRAMdata, rlow_q};
              else        p0_rdata <= {SRAMdata, rlow_q};
            end
            if (port_q) p1_ready <= 1'b1;
            else        p0_ready <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
